// File: rtl/def.sv
// rtl/def.sv - shared types, strobe constants and access-size helpers for the load/store stage.
package def;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} mem_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_e;

   localparam logic [3:0] WSTRB_B = 4'b0001;
   localparam logic [3:0] WSTRB_H = 4'b0011;
   localparam logic [3:0] WSTRB_W = 4'b1111;

   typedef struct packed {
      logic [4:0] rd;
      logic       lb;
      logic       lh;
      logic       lw;
      logic       lbu;
      logic       lhu;
      logic       sb;
      logic       sh;
      logic       sw;
   } instructions;

   function automatic mem_size_e access_size(input instructions i);
      if (i.lw || i.sw) return SZ_W;
      if (i.lh || i.lhu || i.sh) return SZ_H;
      return SZ_B;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] o, input mem_size_e s);
      return ((s == SZ_H) && o[0]) || ((s == SZ_W) && (o != 2'b00));
   endfunction

   function automatic logic [1:0] align_off(input logic [1:0] o, input mem_size_e s);
      case (s)
         SZ_H:    return {o[1], 1'b0};
         SZ_W:    return 2'b00;
         default: return o;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_format.sv
// rtl/mem_load_format.sv - shifts the read word to the byte offset and sign/zero-extends it.
module mem_load_format
   import def::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  offset_i,
   input  mem_size_e   size_i,
   input  logic        unsigned_i,
   output logic [31:0] data_o
);

   logic [31:0] w;

   always_comb begin
      w = rdata_i >> {offset_i, 3'b000};
      case (size_i)
         SZ_B:    data_o = unsigned_i ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         SZ_H:    data_o = unsigned_i ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: data_o = w;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store pipeline stage with one outstanding word request to data memory.
// DMEM_MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing natural alignment.
module mem_access
   import def::*;
#(
   parameter int DMEM_AW = 15
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               enabled,
   input  instructions        instr,
   input  logic [31:0]        addr,
   input  logic [31:0]        store_data,
   output logic               completed,
   output instructions        instr_out,
   output logic [31:0]        rd_out,
   output logic               misaligned,
   output logic               busy,
   output logic               mem_req,
   output logic               mem_we,
   output logic [DMEM_AW-1:0] mem_addr,
   output logic [31:0]        mem_wdata,
   output logic [3:0]         mem_wstrb,
   input  logic               mem_ready,
   input  logic               mem_rvalid,
   input  logic [31:0]        mem_rdata
);

   mem_state_e  state_q;
   mem_size_e   size_q;
   logic [1:0]  off_q;
   logic        uns_q;

   mem_size_e   size_in;
   logic [1:0]  off_in;
   logic        mis_in;
   logic        is_load_in;
   logic        is_store_in;
   logic [3:0]  wstrb_in;
   logic [31:0] wdata_in;
   logic [31:0] load_data;

   assign is_load_in  = instr.lb | instr.lh | instr.lw | instr.lbu | instr.lhu;
   assign is_store_in = instr.sb | instr.sh | instr.sw;
   assign size_in     = access_size(instr);
   assign busy        = (state_q == REQ) || (state_q == WAIT_R);

`ifdef DMEM_MISALIGN_TRAP_EN
   assign mis_in = (is_load_in || is_store_in) && is_misaligned(addr[1:0], size_in);
   assign off_in = addr[1:0];
`else
   assign mis_in = 1'b0;
   assign off_in = align_off(addr[1:0], size_in);
`endif

   always_comb begin
      case (size_in)
         SZ_B: begin
            wdata_in = {4{store_data[7:0]}};
            wstrb_in = WSTRB_B << off_in;
         end
         SZ_H: begin
            wdata_in = {2{store_data[15:0]}};
            wstrb_in = WSTRB_H << off_in;
         end
         default: begin
            wdata_in = store_data;
            wstrb_in = WSTRB_W;
         end
      endcase
   end

   mem_load_format u_fmt (
      .rdata_i    (mem_rdata),
      .offset_i   (off_q),
      .size_i     (size_q),
      .unsigned_i (uns_q),
      .data_o     (load_data)
   );

   // Request signals are registered and only change on acceptance, so they stay stable while stalled.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         completed  <= 1'b0;
         instr_out  <= '0;
         rd_out     <= '0;
         misaligned <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         size_q     <= SZ_B;
         off_q      <= 2'b00;
         uns_q      <= 1'b0;
      end else begin
         completed <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (enabled) begin
                  instr_out  <= instr;
                  size_q     <= size_in;
                  off_q      <= off_in;
                  uns_q      <= instr.lbu | instr.lhu;
                  misaligned <= mis_in;
                  if (mis_in) begin
                     rd_out    <= '0;
                     completed <= 1'b1;
                     state_q   <= DONE;
                  end else if (is_load_in || is_store_in) begin
                     mem_req   <= 1'b1;
                     mem_we    <= is_store_in;
                     mem_addr  <= addr[DMEM_AW+1:2];
                     mem_wdata <= is_store_in ? wdata_in : 32'b0;
                     mem_wstrb <= is_store_in ? wstrb_in : 4'b0;
                     state_q   <= REQ;
                  end else begin
                     rd_out    <= addr;
                     completed <= 1'b1;
                     state_q   <= DONE;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            REQ: begin
               if (mem_ready) begin
                  mem_req   <= 1'b0;
                  mem_we    <= 1'b0;
                  mem_wstrb <= 4'b0;
                  if (mem_we) begin
                     completed <= 1'b1;
                     state_q   <= DONE;
                  end else begin
                     state_q <= WAIT_R;
                  end
               end
            end
            WAIT_R: begin
               if (mem_rvalid) begin
                  rd_out    <= load_data;
                  completed <= 1'b1;
                  state_q   <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed self-checking bench for mem_access.
module tb_mem_access;
   import def::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        enabled = 1'b0;
   instructions instr = '0;
   logic [31:0] addr = '0;
   logic [31:0] store_data = '0;
   logic        completed;
   instructions instr_out;
   logic [31:0] rd_out;
   logic        misaligned;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [14:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int          nerr = 0;
   int          nchk = 0;
   int          lat;
   logic        seen_req;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        req_we;

   instructions i_nop, i_lb, i_lbu, i_lh, i_lhu, i_lw, i_sb, i_sh, i_sw;

   always #5 clk = ~clk;

   mem_access dut (
      .clk        (clk),
      .rstn       (rstn),
      .enabled    (enabled),
      .instr      (instr),
      .addr       (addr),
      .store_data (store_data),
      .completed  (completed),
      .instr_out  (instr_out),
      .rd_out     (rd_out),
      .misaligned (misaligned),
      .busy       (busy),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wstrb  (mem_wstrb),
      .mem_ready  (mem_ready),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input instructions ins, input logic [31:0] a, input logic [31:0] sd);
      instr      = ins;
      addr       = a;
      store_data = sd;
      enabled    = 1'b1;
      seen_req   = 1'b0;
      lat        = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         enabled = 1'b0;
         lat++;
         if (mem_req && !seen_req) begin
            seen_req  = 1'b1;
            req_addr  = 32'(mem_addr);
            req_wdata = mem_wdata;
            req_wstrb = mem_wstrb;
            req_we    = mem_we;
         end
         if (completed) break;
      end
      chk("run_completed", 32'(completed), 32'd1);
   endtask

   initial begin
      i_nop = '0; i_nop.rd = 5'd7;
      i_lb  = '0; i_lb.lb   = 1'b1;
      i_lbu = '0; i_lbu.lbu = 1'b1;
      i_lh  = '0; i_lh.lh   = 1'b1;
      i_lhu = '0; i_lhu.lhu = 1'b1;
      i_lw  = '0; i_lw.lw   = 1'b1;
      i_sb  = '0; i_sb.sb   = 1'b1;
      i_sh  = '0; i_sh.sh   = 1'b1;
      i_sw  = '0; i_sw.sw   = 1'b1;

      #12;
      chk("rst_completed", 32'(completed), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rd_out", rd_out, 32'd0);
      chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
      chk("rst_misaligned", 32'(misaligned), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      run(i_nop, 32'h1234, 32'h0);
      chk("alu_lat", 32'(lat), 32'd1);
      chk("alu_rd", rd_out, 32'h1234);
      chk("alu_noreq", 32'(seen_req), 32'd0);
      chk("alu_instr_out", 32'(instr_out.rd), 32'd7);
      chk("alu_misaligned", 32'(misaligned), 32'd0);
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(completed), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      instr = i_sb; addr = 32'h106; store_data = 32'hAABBCCDD; enabled = 1'b1; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      enabled = 1'b0;
      for (int c = 0; c < 4; c++) begin
         chk("sb_req", 32'(mem_req), 32'd1);
         chk("sb_addr", 32'(mem_addr), 32'h41);
         chk("sb_wdata", mem_wdata, 32'hDDDDDDDD);
         chk("sb_wstrb", 32'(mem_wstrb), 32'h4);
         chk("sb_we", 32'(mem_we), 32'd1);
         chk("sb_busy", 32'(busy), 32'd1);
         chk("sb_stall_nodone", 32'(completed), 32'd0);
         if (c == 3) mem_ready = 1'b1;
         @(posedge clk);
         #1;
      end
      chk("sb_done", 32'(completed), 32'd1);
      chk("sb_req_drop", 32'(mem_req), 32'd0);
      chk("sb_busy_drop", 32'(busy), 32'd0);

      mem_rvalid = 1'b1;
      mem_rdata  = 32'h80FF0000;
      run(i_sw, 32'h10, 32'h12345678);
      chk("sw_lat", 32'(lat), 32'd2);
      chk("sw_addr", req_addr, 32'h4);
      chk("sw_wdata", req_wdata, 32'h12345678);
      chk("sw_wstrb", 32'(req_wstrb), 32'hF);
      chk("sw_we", 32'(req_we), 32'd1);

      run(i_sh, 32'h22, 32'hAABBCCDD);
      chk("sh_lat", 32'(lat), 32'd2);
      chk("sh_addr", req_addr, 32'h8);
      chk("sh_wdata", req_wdata, 32'hCCDDCCDD);
      chk("sh_wstrb", 32'(req_wstrb), 32'hC);

      run(i_lb, 32'h203, 32'h0);
      chk("lb_lat", 32'(lat), 32'd3);
      chk("lb_addr", req_addr, 32'h80);
      chk("lb_we", 32'(req_we), 32'd0);
      chk("lb_rd", rd_out, 32'hFFFFFF80);

      run(i_lbu, 32'h203, 32'h0);
      chk("lbu_rd", rd_out, 32'h00000080);

      run(i_nop, 32'hCAFE, 32'h0);
      chk("b2b_lat", 32'(lat), 32'd1);
      chk("b2b_rd", rd_out, 32'hCAFE);

      mem_rdata = 32'hBEEF1234;
      run(i_lh, 32'h2, 32'h0);
      chk("lh_rd", rd_out, 32'hFFFFBEEF);
      run(i_lhu, 32'h2, 32'h0);
      chk("lhu_rd", rd_out, 32'h0000BEEF);

      mem_rdata = 32'hDEADBEEF;
      run(i_lw, 32'h6, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
      chk("lw_mis_lat", 32'(lat), 32'd1);
      chk("lw_mis_flag", 32'(misaligned), 32'd1);
      chk("lw_mis_rd", rd_out, 32'd0);
      chk("lw_mis_noreq", 32'(seen_req), 32'd0);
`else
      chk("lw_aln_lat", 32'(lat), 32'd3);
      chk("lw_aln_addr", req_addr, 32'h1);
      chk("lw_aln_rd", rd_out, 32'hDEADBEEF);
      chk("lw_aln_flag", 32'(misaligned), 32'd0);
`endif

      mem_ready = 1'b0;
      instr = i_sw; addr = 32'h40; store_data = 32'h55; enabled = 1'b1;
      @(posedge clk);
      #1;
      enabled = 1'b0;
      chk("rstreq_req", 32'(mem_req), 32'd1);
      rstn = 1'b0;
      #1;
      chk("rstreq_req_drop", 32'(mem_req), 32'd0);
      chk("rstreq_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      mem_ready = 1'b1;

      mem_rvalid = 1'b0;
      instr = i_lw; addr = 32'h44; enabled = 1'b1;
      @(posedge clk);
      #1;
      enabled = 1'b0;
      @(posedge clk);
      #1;
      chk("waitr_busy", 32'(busy), 32'd1);
      rstn = 1'b0;
      #1;
      chk("waitr_rst_busy", 32'(busy), 32'd0);
      chk("waitr_rst_req", 32'(mem_req), 32'd0);
      chk("waitr_rst_done", 32'(completed), 32'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      mem_rvalid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         chk("late_rvalid_ignored", 32'(completed), 32'd0);
      end
      mem_rdata = 32'h13579BDF;
      run(i_lw, 32'h44, 32'h0);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_rd", rd_out, 32'h13579BDF);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
